// File: rtl/waveform_gen_mc.sv
// Multi-channel DDS wave/noise generator: channels are evaluated one per cycle after each sample tick and summed with saturation.
// Optional macro WAVEFORM_GEN_SINE_LUT_EN builds the quarter-wave sine ROM; without it SINE mode outputs 0.
module waveform_gen_mc #(
   parameter int WIDTH    = 24,
   parameter int DEPTH    = 1024,
   parameter int CHANNELS = 2,
   parameter int PHASE_W  = 32
) (
   input  logic                                               i_clk,
   input  logic                                               i_rst,
   input  logic                                               i_cfg_valid,
   output logic                                               o_cfg_ready,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_cfg_ch,
   input  logic [2:0]                                         i_cfg_mode,
   input  logic [PHASE_W-1:0]                                 i_cfg_step,
   input  logic [2:0]                                         i_cfg_duty,
   input  logic [1:0]                                         i_cfg_gain,
   input  logic                                               i_sample_tick,
   output logic                                               o_valid,
   output logic [WIDTH-1:0]                                   o_sample,
   output logic                                               o_overrun
);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int ACC_W = WIDTH + $clog2(CHANNELS) + 1;
   localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] MAXV_A = ACC_W'(MAXV);
   localparam logic signed [ACC_W-1:0] MINV_A = ACC_W'(MINV);
   localparam logic [2:0] M_SINE = 3'd1, M_SQUARE = 3'd2, M_TRI = 3'd3, M_SAW = 3'd4, M_NOISE = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

   state_t                    state_q, state_d;
   logic [CH_W-1:0]           ch_q, ch_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [PHASE_W-1:0]        phase_q [CHANNELS], phase_d [CHANNELS];
   logic [PHASE_W-1:0]        step_q  [CHANNELS], step_d  [CHANNELS];
   logic [2:0]                mode_q  [CHANNELS], mode_d  [CHANNELS];
   logic [2:0]                duty_q  [CHANNELS], duty_d  [CHANNELS];
   logic [1:0]                gain_q  [CHANNELS], gain_d  [CHANNELS];
   logic [31:0]               lfsr_q  [CHANNELS], lfsr_d  [CHANNELS];
   logic [WIDTH-1:0]          o_sample_q, o_sample_d;
   logic                      o_valid_q, o_valid_d, o_overrun_q, o_overrun_d;

   logic [PHASE_W-1:0]        cur_p;
   logic [WIDTH-1:0]          u, u2;
   logic signed [WIDTH-1:0]   shape, scaled, sine_v;
   logic signed [ACC_W-1:0]   acc_sum;
   logic [31:0]               lfsr_next;

   assign cur_p     = phase_q[ch_q];
   assign u         = cur_p[PHASE_W-1 -: WIDTH];
   assign u2        = {u[WIDTH-2:0], 1'b0};
   // Right-shifting Galois form of x^32+x^22+x^2+x+1
   assign lfsr_next = {1'b0, lfsr_q[ch_q][31:1]} ^ (lfsr_q[ch_q][0] ? 32'h8020_0003 : 32'h0);

`ifdef WAVEFORM_GEN_SINE_LUT_EN
   localparam int LG_D = $clog2(DEPTH);
   localparam int QD   = DEPTH / 4;

   function automatic logic signed [WIDTH-1:0] sin_entry(input int i);
      real r;
      r = real'(MAXV) * $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(DEPTH));
      return WIDTH'(longint'($floor(r + 0.5)));
   endfunction

   logic signed [WIDTH-1:0] sin_rom [QD+1];
   for (genvar gi = 0; gi <= QD; gi++) begin : g_rom
      assign sin_rom[gi] = sin_entry(gi);
   end

   logic [LG_D-1:0] s_idx;
   logic [LG_D-2:0] s_ridx;
   assign s_idx  = cur_p[PHASE_W-1 -: LG_D];
   // Odd quadrants read the table backwards, the lower half-period is negated
   assign s_ridx = s_idx[LG_D-2] ? ((LG_D-1)'(QD) - {1'b0, s_idx[LG_D-3:0]}) : {1'b0, s_idx[LG_D-3:0]};
   assign sine_v = s_idx[LG_D-1] ? -sin_rom[s_ridx] : sin_rom[s_ridx];
`else
   assign sine_v = '0;
`endif

   always_comb begin
      shape = '0;
      case (mode_q[ch_q])
         M_SINE:   shape = sine_v;
         M_SQUARE: shape = (cur_p[PHASE_W-1 -: 3] <= duty_q[ch_q]) ? MAXV : -MAXV;
         M_TRI:    shape = u[WIDTH-1] ? (MAXV - $signed(u2)) : ($signed(u2) + MINV);
         M_SAW:    shape = $signed({~u[WIDTH-1], u[WIDTH-2:0]});
         M_NOISE:  shape = $signed(lfsr_q[ch_q][31 -: WIDTH]);
         default:  shape = '0;
      endcase
      scaled  = shape >>> gain_q[ch_q];
      acc_sum = acc_q + ACC_W'(scaled);
   end

   assign o_cfg_ready = (state_q == S_IDLE);

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      acc_d       = acc_q;
      phase_d     = phase_q;
      step_d      = step_q;
      mode_d      = mode_q;
      duty_d      = duty_q;
      gain_d      = gain_q;
      lfsr_d      = lfsr_q;
      o_sample_d  = o_sample_q;
      o_valid_d   = 1'b0;
      o_overrun_d = i_sample_tick && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            for (int k = 0; k < CHANNELS; k++) begin
               if (i_cfg_valid && (i_cfg_ch == CH_W'(k))) begin
                  mode_d[k]  = i_cfg_mode;
                  step_d[k]  = i_cfg_step;
                  duty_d[k]  = i_cfg_duty;
                  gain_d[k]  = i_cfg_gain;
                  phase_d[k] = '0;
               end
            end
            if (i_sample_tick) begin
               state_d = S_RUN;
               ch_d    = '0;
               acc_d   = '0;
            end
         end
         S_RUN: begin
            phase_d[ch_q] = cur_p + step_q[ch_q];
            if (mode_q[ch_q] == M_NOISE) lfsr_d[ch_q] = lfsr_next;
            acc_d = acc_sum;
            if (ch_q == CH_W'(CHANNELS-1)) begin
               state_d   = S_OUT;
               o_valid_d = 1'b1;
               if (acc_sum > MAXV_A)      o_sample_d = MAXV;
               else if (acc_sum < MINV_A) o_sample_d = MINV;
               else                       o_sample_d = acc_sum[WIDTH-1:0];
            end else begin
               ch_d = ch_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         acc_q       <= '0;
         o_sample_q  <= '0;
         o_valid_q   <= 1'b0;
         o_overrun_q <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            phase_q[k] <= '0;
            step_q[k]  <= '0;
            mode_q[k]  <= '0;
            duty_q[k]  <= '0;
            gain_q[k]  <= '0;
            lfsr_q[k]  <= 32'hACE1 + 32'(k);
         end
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         o_sample_q  <= o_sample_d;
         o_valid_q   <= o_valid_d;
         o_overrun_q <= o_overrun_d;
         phase_q     <= phase_d;
         step_q      <= step_d;
         mode_q      <= mode_d;
         duty_q      <= duty_d;
         gain_q      <= gain_d;
         lfsr_q      <= lfsr_d;
      end
   end

   assign o_valid   = o_valid_q;
   assign o_sample  = o_sample_q;
   assign o_overrun = o_overrun_q;
endmodule

// File: tb/tb_waveform_gen_mc.sv
// Bench for waveform_gen_mc (WIDTH=24, CHANNELS=2): vector table, corner sequences and a randomized run against a reference model.
module tb_waveform_gen_mc;
   localparam longint MAXV = 8388607;
   localparam longint HALF = 8388608;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cfg_valid = 1'b0, cfg_ready;
   logic [0:0]  cfg_ch = '0;
   logic [2:0]  cfg_mode = '0, cfg_duty = '0;
   logic [31:0] cfg_step = '0;
   logic [1:0]  cfg_gain = '0;
   logic        tick = 1'b0, valid, overrun;
   logic [23:0] sample;

   int total = 0, bad = 0;

   waveform_gen_mc #(.WIDTH(24), .DEPTH(1024), .CHANNELS(2), .PHASE_W(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
      .i_cfg_ch(cfg_ch), .i_cfg_mode(cfg_mode), .i_cfg_step(cfg_step),
      .i_cfg_duty(cfg_duty), .i_cfg_gain(cfg_gain), .i_sample_tick(tick),
      .o_valid(valid), .o_sample(sample), .o_overrun(overrun));

   always #5 clk = ~clk;

   // reference model state
   longint      m_phase [2];
   logic [2:0]  m_mode  [2];
   logic [31:0] m_step  [2];
   logic [2:0]  m_duty  [2];
   logic [1:0]  m_gain  [2];
   logic [31:0] m_lfsr  [2];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_phase[k] = 0; m_mode[k] = 0; m_step[k] = 0; m_duty[k] = 0; m_gain[k] = 0;
         m_lfsr[k] = 32'hACE1 + 32'(k);
      end
   endtask

   task automatic model_cfg(input int ch, input logic [2:0] mo, input logic [31:0] st,
                            input logic [2:0] du, input logic [1:0] ga);
      m_mode[ch] = mo; m_step[ch] = st; m_duty[ch] = du; m_gain[ch] = ga; m_phase[ch] = 0;
   endtask

   task automatic model_tick(output longint e);
      longint sum, v, p, u;
      sum = 0;
      for (int k = 0; k < 2; k++) begin
         p = m_phase[k];
         u = p >> 8;
         case (m_mode[k])
`ifdef WAVEFORM_GEN_SINE_LUT_EN
            3'd1: v = longint'($floor(real'(MAXV) * $sin(2.0 * 3.141592653589793 * real'(p >> 22) / 1024.0) + 0.5));
`else
            3'd1: v = 0;
`endif
            3'd2: v = ((p >> 29) <= longint'(m_duty[k])) ? MAXV : -MAXV;
            3'd3: v = (u < HALF) ? (2 * u - HALF) : (MAXV - 2 * (u - HALF));
            3'd4: v = u - HALF;
            3'd5: begin
               v = longint'($signed(m_lfsr[k][31:8]));
               m_lfsr[k] = (m_lfsr[k] >> 1) ^ (m_lfsr[k][0] ? 32'h8020_0003 : 32'h0);
            end
            default: v = 0;
         endcase
         sum += v >>> m_gain[k];
         m_phase[k] = (p + longint'(m_step[k])) & 64'hFFFF_FFFF;
      end
      e = (sum > MAXV) ? MAXV : (sum < -HALF) ? -HALF : sum;
   endtask

   task automatic cfg_write(input int ch, input logic [2:0] mo, input logic [31:0] st,
                            input logic [2:0] du, input logic [1:0] ga);
      cfg_valid = 1'b1; cfg_ch = 1'(ch); cfg_mode = mo; cfg_step = st; cfg_duty = du; cfg_gain = ga;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      model_cfg(ch, mo, st, du, ga);
   endtask

   // Issue one tick from IDLE, expect o_valid CHANNELS+1 edges later for exactly one cycle
   task automatic do_tick(input string name, input longint tbl_exp, input bit has_tbl);
      longint e;
      int n;
      model_tick(e);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0; cfg_valid = 1'b0;
      n = 1;
      while (!valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_latency"}, n, 3);
      chk({name, "_model"}, longint'($signed(sample)), e);
      if (has_tbl) chk({name, "_table"}, longint'($signed(sample)), tbl_exp);
      @(posedge clk); #1;
      chk({name, "_strobe_off"}, valid, 0);
   endtask

   typedef struct {
      bit          cfg;
      logic [2:0]  m0, m1;
      logic [31:0] s0, s1;
      logic [2:0]  d0, d1;
      logic [1:0]  g0, g1;
      longint      exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t row(bit c, logic [2:0] m0, logic [2:0] m1, logic [31:0] s0, logic [31:0] s1,
                                logic [2:0] d0, logic [2:0] d1, logic [1:0] g0, logic [1:0] g1, longint e);
      vec_t r;
      r.cfg = c; r.m0 = m0; r.m1 = m1; r.s0 = s0; r.s1 = s1;
      r.d0 = d0; r.d1 = d1; r.g0 = g0; r.g1 = g1; r.exp = e;
      return r;
   endfunction

   initial begin
      longint e;
      int n, nv;

      // square, then saw+tri, then saturation, then sine
      for (int i = 0; i < 8; i++)
         tbl.push_back(row(i == 0, 3'd2, 3'd0, 32'h2000_0000, 0, 3, 0, 0, 0, (i < 4) ? MAXV : -MAXV));
      tbl.push_back(row(1, 3'd4, 3'd3, 32'h4000_0000, 32'h4000_0000, 0, 0, 1, 1, -8388608));
      tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, -2097152));
      tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 4194303));
      tbl.push_back(row(1, 3'd2, 3'd2, 32'h2000_0000, 32'h2000_0000, 7, 7, 0, 0, MAXV));
      tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, MAXV));
      for (int i = 0; i < 8; i++)
         tbl.push_back(row(i == 0, 3'd2, 3'd2, 32'h2000_0000, 32'h2000_0000, 0, 0, 0, 0, (i == 0) ? MAXV : -HALF));
      for (int i = 0; i < 4; i++)
`ifdef WAVEFORM_GEN_SINE_LUT_EN
         tbl.push_back(row(i == 0, 3'd1, 3'd0, 32'h4000_0000, 0, 0, 0, 0, 0, (i == 1) ? MAXV : (i == 3) ? -MAXV : 0));
`else
         tbl.push_back(row(i == 0, 3'd1, 3'd0, 32'h4000_0000, 0, 0, 0, 0, 0, 0));
`endif

      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_valid", valid, 0);
      chk("rst_sample", longint'($signed(sample)), 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_ready", cfg_ready, 1);
      do_tick("rst_default", 0, 1'b1);

      foreach (tbl[i]) begin
         if (tbl[i].cfg) begin
            cfg_write(0, tbl[i].m0, tbl[i].s0, tbl[i].d0, tbl[i].g0);
            cfg_write(1, tbl[i].m1, tbl[i].s1, tbl[i].d1, tbl[i].g1);
         end
         do_tick($sformatf("vec%0d", i), tbl[i].exp, 1'b1);
      end

      // back-to-back tick: second one is dropped and flagged
      cfg_write(0, 3'd2, 32'h0, 7, 0);
      cfg_write(1, 3'd0, 32'h0, 0, 0);
      model_tick(e);
      tick = 1'b1;
      @(posedge clk); #1;
      chk("ovr_quiet", overrun, 0);
      @(posedge clk); #1;
      tick = 1'b0;
      chk("ovr_pulse", overrun, 1);
      nv = 0;
      for (int c = 0; c < 8; c++) begin
         if (valid) begin
            nv++;
            chk("ovr_sample", longint'($signed(sample)), e);
         end
         @(posedge clk); #1;
         if (c == 0) chk("ovr_pulse_end", overrun, 0);
      end
      chk("ovr_valid_count", nv, 1);

      // config held through RUN/OUT is only taken in IDLE and clears the phase
      cfg_write(0, 3'd4, 32'h4000_0000, 0, 0);
      model_tick(e);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_mode = 3'd4; cfg_step = 32'h4000_0000; cfg_duty = 0; cfg_gain = 0;
      n = 0; nv = 0;
      while (!cfg_ready && n < 10) begin
         if (valid) begin
            nv++;
            chk("hold_sample", longint'($signed(sample)), e);
         end
         @(posedge clk); #1;
         n++;
      end
      chk("hold_wait", n, 3);
      chk("hold_valid_seen", nv, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      model_cfg(0, 3'd4, 32'h4000_0000, 0, 0);
      do_tick("hold_phase_clr", -8388608, 1'b1);

      // config and tick in the same IDLE cycle: new settings, phase 0
      cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_mode = 3'd3; cfg_step = 32'h1000_0000; cfg_duty = 0; cfg_gain = 1;
      model_cfg(1, 3'd3, 32'h1000_0000, 0, 1);
      do_tick("cfg_and_tick", -8388608, 1'b1);

      // reset inside RUN aborts the sample and restores defaults
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      rst = 1'b1;
      #1;
      nv = 0;
      for (int c = 0; c < 4; c++) begin
         if (valid) nv++;
         @(posedge clk); #1;
      end
      chk("rst_run_no_valid", nv, 0);
      chk("rst_run_sample", longint'($signed(sample)), 0);
      rst = 1'b0;
      model_reset();
      nv = 0;
      for (int c = 0; c < 4; c++) begin
         if (valid) nv++;
         @(posedge clk); #1;
      end
      chk("rst_run_after", nv, 0);
      do_tick("rst_run_default", 0, 1'b1);

      // randomized configs, including noise and the aliased OFF codes
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) != 0)
            cfg_write(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         if (i % 8 == 0) cfg_write(i % 16 == 0 ? 0 : 1, 3'd5, $urandom, 0, 2'($urandom_range(0, 3)));
         do_tick($sformatf("rnd%0d", i), 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
